// File: rtl/wr_rptr_sync_full.sv
// Write-domain receiver of the async FIFO read pointer: Gray synchronizer, full compare,
// registered fill level, almost-full and sticky overflow.
module wr_rptr_sync_full #(
  parameter int unsigned C_DEPTH_BITS   = 10,
  parameter int unsigned C_SYNC_STAGES  = 2,
  parameter int unsigned C_AFULL_THRESH = (1 << C_DEPTH_BITS) - 4
) (
  input  logic                    WR_CLK,
  input  logic                    WR_RST,
  input  logic [C_DEPTH_BITS-1:0] rd_ptr_gray_i,
  input  logic [C_DEPTH_BITS-1:0] wr_ptr_i,
  input  logic                    wr_en_i,
  output logic                    cmp_full_o,
  output logic [C_DEPTH_BITS-1:0] wr_level_o,
  output logic                    wr_afull_o,
  output logic                    wr_ovf_o,
  output logic [C_DEPTH_BITS-1:0] rd_ptr_sync_o
);

  localparam int unsigned N = C_DEPTH_BITS;
  localparam logic [N-1:0] AfullThresh = C_AFULL_THRESH[N-1:0];

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = int'(N) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [N-1:0] sync_q [C_SYNC_STAGES];
  logic [N-1:0] rd_bin, wr_bin, wr_inc;
  logic [N-1:0] level_d, level_q;
  logic         afull_d, afull_q;
  logic         ovf_d, ovf_q;
  logic         cmp_full;

  // Plain flop chain; Gray coding keeps each sample within one bit of a legal value.
  always_ff @(posedge WR_CLK or posedge WR_RST) begin
    if (WR_RST) begin
      for (int i = 0; i < int'(C_SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd_ptr_gray_i;
      for (int i = 1; i < int'(C_SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_comb begin
    rd_bin   = gray2bin(sync_q[C_SYNC_STAGES-1]);
    wr_bin   = gray2bin(wr_ptr_i);
    wr_inc   = wr_bin + N'(1);
    // Lagging read pointer makes this conservative: full clears late, never early.
    cmp_full = !WR_RST && (wr_inc == rd_bin);
    level_d  = wr_bin - rd_bin;
    afull_d  = (level_d >= AfullThresh);
    ovf_d    = ovf_q | (wr_en_i & cmp_full);
  end

  always_ff @(posedge WR_CLK or posedge WR_RST) begin
    if (WR_RST) begin
      level_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cmp_full_o    = cmp_full;
  assign wr_level_o    = level_q;
  assign wr_afull_o    = afull_q;
  assign wr_ovf_o      = ovf_q;
  assign rd_ptr_sync_o = sync_q[C_SYNC_STAGES-1];

endmodule

// File: doc/wr_rptr_sync_full.md
# wr_rptr_sync_full

Write-domain receiver of the read pointer for the async FIFO. Synchronizes the Gray-coded read pointer from the read clock domain into WR_CLK, converts it and the local write pointer to binary, and produces the full compare (CMP_FULL) consumed by the write-pointer block. It also produces a registered fill level, an almost-full flag and a sticky overflow flag. It sits beside the write-pointer/full block, and its outputs drive the writer's full logic and upstream flow control.

## Interface
- C_DEPTH_BITS, 10, pointer width N. FIFO has 2^N slots; usable capacity is 2^N-1 (one slot reserved).
- C_SYNC_STAGES, 2, number of synchronizer flops, legal range 2..4.
- C_AFULL_THRESH, 2^N-4, WR_AFULL asserts when level >= this value, legal range 1..2^N-1.
- Clocks/resets: WR_RST, asynchronous, active-high; clock WR_CLK.
- WR_CLK  in  1  write-domain clock.
- WR_RST  in  1  asynchronous active-high reset; clears all state.
- RD_PTR_GRAY  in  N  Gray read pointer, launched from read-domain flops; asynchronous to WR_CLK.
- WR_PTR  in  N  registered Gray write pointer from the write-pointer block.
- WR_EN  in  1  write request, used only for overflow detection.
- CMP_FULL  out  1  full compare: the next write would hit the synchronized read pointer.
- WR_LEVEL  out  N  registered occupancy, 0..2^N-1.
- WR_AFULL  out  1  registered almost-full.
- WR_OVF  out  1  sticky flag: write attempted while full.
- RD_PTR_SYNC  out  N  synchronized Gray read pointer (last sync stage), for debug.

## Operation
- Synchronizer: a chain of C_SYNC_STAGES flops on RD_PTR_GRAY. There is no logic between stages, and the first stage samples RD_PTR_GRAY raw. Gray coding guarantees at most one bit changes per read increment.
- Gray to binary: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i]. This is applied to RD_PTR_SYNC (rd_bin) and to WR_PTR (wr_bin). Both are combinational.
- CMP_FULL is combinational: ((wr_bin+1) mod 2^N) == rd_bin, and it is forced 0 while WR_RST is high.
  - It depends only on registered signals (WR_PTR and the last sync stage), so it is glitch-free per cycle.
  - It is conservative: rd_sync lags the true read pointer, so full deasserts late and never early.
- WR_LEVEL is registered: (wr_bin - rd_bin) mod 2^N, an N-bit wrap subtraction with the carry discarded.
- WR_AFULL is registered: it is computed from the same next-level value as WR_LEVEL, so both update on the same edge.
- WR_OVF is set on any WR_CLK edge where WR_EN=1 and CMP_FULL=1. It stays set until WR_RST.
- Wrap-around: the pointers wrap modulo 2^N. Full at the wrap point is wr_bin=2^N-1 with rd_bin=0, and it must be detected.
- Empty, or both pointers equal at any value: level 0, CMP_FULL=0.

## Timing
- Reset values, asserted asynchronously: all sync stages 0, RD_PTR_SYNC 0, WR_LEVEL 0, WR_AFULL 0, WR_OVF 0, CMP_FULL 0.
- Once WR_RST deasserts with WR_PTR=0, CMP_FULL remains 0.
- A change on RD_PTR_GRAY appears on RD_PTR_SYNC after C_SYNC_STAGES WR_CLK rising edges. The change is visible on CMP_FULL in the same cycle and on WR_LEVEL/WR_AFULL one edge later.
- A change on WR_PTR affects CMP_FULL combinationally in the same cycle. It appears on WR_LEVEL/WR_AFULL after 1 edge.
- Simultaneous WR_PTR and rd_sync changes are both reflected in the same cycle; no ordering priority exists.
- Reset mid-operation: all outputs return to reset values immediately. The synchronizer restarts from 0, and the read domain must also be reset.
- WR_OVF asserts one edge after the offending WR_EN&CMP_FULL cycle.

## Test plan
N=4, C_SYNC_STAGES=2, C_AFULL_THRESH=12 unless stated otherwise.
- **Reset:** assert WR_RST mid-cycle with random inputs -> all outputs 0 immediately; after release with WR_PTR=gray(0) and RD_PTR_GRAY=0 -> CMP_FULL=0, WR_LEVEL=0.
- **Fill to full:** step WR_PTR gray(0)..gray(15) with RD_PTR_GRAY=0 -> WR_LEVEL follows 1..15 with a 1-cycle lag; WR_AFULL=1 from level 12; CMP_FULL=1 exactly when WR_PTR=gray(15).
- **Sync latency:** hold WR_PTR=gray(15), RD_PTR_GRAY=0, then set RD_PTR_GRAY=gray(1) -> CMP_FULL drops exactly 2 edges later; WR_LEVEL goes 15->14 one edge after that.
- **Wrap-around:** WR_PTR=gray(3) and rd=gray(4) after sync -> CMP_FULL=1, WR_LEVEL=15; then WR_PTR=gray(2) and rd=gray(14) -> WR_LEVEL=4, CMP_FULL=0.
- **Overflow:** while CMP_FULL=1, pulse WR_EN for 1 cycle -> WR_OVF=1 next edge; WR_OVF stays 1 after full clears; WR_RST clears it.
- **C_SYNC_STAGES=3 regression:** repeat the sync-latency case -> CMP_FULL drops 3 edges after the RD_PTR_GRAY change.
